// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a big-endian byte stream into imem words and holds the core in reset until loaded
//
// Ports:
//   Clk          rising-edge system clock
//   Reset        asynchronous active-low reset
//   in_valid     stream byte valid
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (handshake = in_valid & in_ready)
//   reload       one-cycle pulse restarting the load from DONE or ERR
//   im_we        imem write strobe (one-cycle pulse)
//   im_addr      imem word address
//   im_wdata     imem write data
//   cpu_hold     1 holds the core in reset
//   boot_err     sticky error flag, cleared by reload or Reset
//   words_loaded payload words written during the current load
//
// Build option: define BOOT_CHECKSUM_EN to append a 32-bit payload checksum word
// after the image; a mismatching checksum sends the loader to ERR.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              boot_err,
    output logic [ADDR_W:0]   words_loaded
);
`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {HDR, LOAD, DONE, ERR} state_t;
`endif
    localparam logic [32:0]       CAP  = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [23:0]       r_acc;
    logic [ADDR_W:0]   r_n;
    logic              w_hs;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_wl_nx;
    assign w_hs    = in_valid & in_ready;
    assign w_word  = {r_acc, in_data};
    assign w_wl_nx = words_loaded + 1'b1;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] r_sum;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            r_sum <= '0;
        else if ((r_state == DONE || r_state == ERR) && reload)
            r_sum <= '0;
        else if (r_state == LOAD && w_hs && r_cnt == 2'd3)
            r_sum <= r_sum + w_word;
    end
`endif
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= HDR;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_n          <= '0;
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= BASE;
            im_wdata     <= '0;
            cpu_hold     <= 1'b1;
            boot_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_we <= 1'b0;
            if (r_state == DONE || r_state == ERR) begin
                cpu_hold <= (r_state == ERR) | reload;
                if (reload) begin
                    r_state      <= HDR;
                    r_cnt        <= '0;
                    r_acc        <= '0;
                    in_ready     <= 1'b1;
                    boot_err     <= 1'b0;
                    words_loaded <= '0;
                end
            end else begin
                in_ready <= 1'b1;
                if (w_hs) begin
                    r_cnt <= r_cnt + 2'd1;
                    r_acc <= w_word[23:0];
                    if (r_cnt == 2'd3) begin
                        if (r_state == HDR) begin
                            r_n <= w_word[ADDR_W:0];
                            if (w_word == '0) begin
`ifdef BOOT_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state  <= DONE;
                                in_ready <= 1'b0;
`endif
                            end else if ({1'b0, w_word} > CAP) begin
                                r_state  <= ERR;
                                in_ready <= 1'b0;
                                boot_err <= 1'b1;
                            end else
                                r_state <= LOAD;
                        end else if (r_state == LOAD) begin
                            im_we        <= 1'b1;
                            im_wdata     <= w_word;
                            // wraps naturally at 2**ADDR_W via the truncated add
                            im_addr      <= BASE + words_loaded[ADDR_W-1:0];
                            words_loaded <= w_wl_nx;
                            if (w_wl_nx == r_n) begin
`ifdef BOOT_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state  <= DONE;
                                in_ready <= 1'b0;
`endif
                            end
                        end
`ifdef BOOT_CHECKSUM_EN
                        else begin
                            in_ready <= 1'b0;
                            r_state  <= (w_word == r_sum) ? DONE : ERR;
                            boot_err <= (w_word != r_sum);
                        end
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        boot_err;
    logic [8:0]  words_loaded;
    int total = 0;
    int bad = 0;
    int wr_n = 0;
    logic [7:0]  wr_addr [16];
    logic [31:0] wr_data [16];

    imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_hold(cpu_hold), .boot_err(boot_err),
        .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        if (im_we) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] = im_addr;
                wr_data[wr_n] = im_wdata;
            end
            wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called on a falling edge; returns on the falling edge after the handshake edge
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge Clk);
        reload = 1'b0;
    endtask

    initial begin
        idle(2);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        Reset = 1'b1;
        idle(2);
        chk("t1_hold", 32'(cpu_hold), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        chk("t1_we", 32'(im_we), 32'd0);
        chk("t1_wl", 32'(words_loaded), 32'd0);

        // two-word image streamed back to back
        wr_n = 0;
        send_word(32'h0000_0002);
        send_word(32'h3c10_ffff);
        send_word(32'h3610_0001);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'h7221_0000);
`endif
        idle(2);
        chk("t2_wr_n", 32'(wr_n), 32'd2);
        chk("t2_addr0", 32'(wr_addr[0]), 32'd0);
        chk("t2_data0", wr_data[0], 32'h3c10_ffff);
        chk("t2_addr1", 32'(wr_addr[1]), 32'd1);
        chk("t2_data1", wr_data[1], 32'h3610_0001);
        chk("t2_wl", 32'(words_loaded), 32'd2);
        chk("t2_hold", 32'(cpu_hold), 32'd0);
        chk("t2_ready", 32'(in_ready), 32'd0);
        chk("t2_err", 32'(boot_err), 32'd0);

        // oversize header: N=257 with 256-word capacity
        pulse_reload();
        chk("t3_reload_ready", 32'(in_ready), 32'd1);
        chk("t3_reload_hold", 32'(cpu_hold), 32'd1);
        chk("t3_reload_wl", 32'(words_loaded), 32'd0);
        wr_n = 0;
        send_word(32'h0000_0101);
        idle(2);
        chk("t3_err", 32'(boot_err), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        chk("t3_wr_n", 32'(wr_n), 32'd0);
        // reload with a byte offered in the same cycle: the byte must not be taken
        in_valid = 1'b1;
        in_data  = 8'haa;
        pulse_reload();
        in_valid = 1'b0;
        chk("t3_clr_err", 32'(boot_err), 32'd0);
        chk("t3_clr_ready", 32'(in_ready), 32'd1);

        // empty image
        send_word(32'h0000_0000);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'h0000_0000);
`else
        chk("t4_hold_entry", 32'(cpu_hold), 32'd1);
`endif
        @(negedge Clk);
        chk("t4_hold", 32'(cpu_hold), 32'd0);
        chk("t4_wr_n", 32'(wr_n), 32'd0);
        chk("t4_wl", 32'(words_loaded), 32'd0);

        // stall between bytes 2 and 3 of the only word
        pulse_reload();
        wr_n = 0;
        send_word(32'h0000_0001);
        send(8'h3c);
        send(8'h10);
        idle(5);
        chk("t5_stall_we", 32'(wr_n), 32'd0);
        send(8'hff);
        send(8'hff);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'h3c10_ffff);
`endif
        idle(3);
        chk("t5_wr_n", 32'(wr_n), 32'd1);
        chk("t5_data", wr_data[0], 32'h3c10_ffff);
        chk("t5_wdata", im_wdata, 32'h3c10_ffff);
        chk("t5_hold", 32'(cpu_hold), 32'd0);

`ifdef BOOT_CHECKSUM_EN
        // wrong checksum
        pulse_reload();
        send_word(32'h0000_0002);
        send_word(32'h3c10_ffff);
        send_word(32'h3610_0001);
        send_word(32'h0000_0000);
        idle(3);
        chk("t6_err", 32'(boot_err), 32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
`endif

        // async reset in the middle of LOAD
        pulse_reload();
        send_word(32'h0000_0002);
        send_word(32'h3c10_ffff);
        send(8'h36);
        send(8'h10);
        chk("t6_wl_before", 32'(words_loaded), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("t6_rst_wl", 32'(words_loaded), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        chk("t6_rst_hold", 32'(cpu_hold), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        idle(2);
        wr_n = 0;
        send_word(32'h0000_0001);
        send_word(32'h1122_3344);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'h1122_3344);
`endif
        idle(2);
        chk("t6_after_wr_n", 32'(wr_n), 32'd1);
        chk("t6_after_addr", 32'(wr_addr[0]), 32'd0);
        chk("t6_after_data", wr_data[0], 32'h1122_3344);
        chk("t6_after_hold", 32'(cpu_hold), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
